// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory shared by the CPU and the DMNI DMA.
// DMA has priority; a burst counter forces a CPU slot after MAX_DMA_BURST consecutive DMA grants.
module dmem_arbiter #(
  parameter int MAX_DMA_BURST = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        cpu_en_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall_o,

  input  logic        dma_req_i,
  input  logic [3:0]  dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_data_i,
  output logic        dma_gnt_o,
  output logic [31:0] dma_data_o,
  output logic        dma_rvalid_o,

  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_DMA_BURST);

  logic [7:0] r_burst_cnt;
  owner_e     r_owner;

  logic       w_force_cpu;
  logic       w_dma_grant;
  logic       w_cpu_grant;
  logic       w_cpu_owns;
  logic       w_dma_owns;

  // Grants are suppressed while reset is low so no access reaches memory during reset.
  assign w_force_cpu = cpu_en_i && (r_burst_cnt >= BURST_LIMIT);
  assign w_dma_grant = rst_ni && dma_req_i && !w_force_cpu;
  assign w_cpu_grant = rst_ni && cpu_en_i && !w_dma_grant;

  assign cpu_stall_o = cpu_en_i && !w_cpu_grant;
  assign dma_gnt_o   = dma_req_i && w_dma_grant;

  // The owner register may still hold a pre-reset read; gating with rst_ni discards it.
  assign w_cpu_owns   = rst_ni && (r_owner == OWN_CPU);
  assign w_dma_owns   = rst_ni && (r_owner == OWN_DMA);
  assign cpu_data_o   = w_cpu_owns ? mem_data_i : 32'h0;
  assign dma_data_o   = w_dma_owns ? mem_data_i : 32'h0;
  assign dma_rvalid_o = w_dma_owns;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 4'h0;
    mem_addr_o = cpu_addr_i;
    mem_data_o = cpu_data_i;
    if (w_dma_grant) begin
      mem_en_o   = 1'b1;
      mem_we_o   = dma_we_i;
      mem_addr_o = dma_addr_i;
      mem_data_o = dma_data_i;
    end else if (w_cpu_grant) begin
      mem_en_o   = 1'b1;
      mem_we_o   = cpu_we_i;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_burst_cnt <= 8'd0;
      r_owner     <= OWN_NONE;
    end else begin
      if (!cpu_en_i || w_cpu_grant) begin
        r_burst_cnt <= 8'd0;
      end else if (w_dma_grant) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end

      if (w_dma_grant && (dma_we_i == 4'h0)) begin
        r_owner <= OWN_DMA;
      end else if (w_cpu_grant && (cpu_we_i == 4'h0)) begin
        r_owner <= OWN_CPU;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with MAX_DMA_BURST=4; each row is one clock cycle.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_en_i;
  logic [3:0]  cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic        cpu_stall_o;
  logic        dma_req_i;
  logic [3:0]  dma_we_i;
  logic [31:0] dma_addr_i, dma_data_i, dma_data_o;
  logic        dma_gnt_o, dma_rvalid_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.MAX_DMA_BURST(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_en_i(cpu_en_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i), .dma_data_i(dma_data_i),
    .dma_gnt_o(dma_gnt_o), .dma_data_o(dma_data_o), .dma_rvalid_o(dma_rvalid_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  typedef struct {
    logic [63:0] tag;
    logic        rst_n, ce;
    logic [3:0]  cwe;
    logic [31:0] ca, cd;
    logic        dr;
    logic [3:0]  dwe;
    logic [31:0] da, dd, md;
    logic        stall, gnt, men;
    logic [3:0]  mwe;
    logic [31:0] maddr, mwd, crd;
    logic        rv;
    logic [31:0] drd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(
    input logic [63:0] tag, input logic rst_n, input logic ce, input logic [3:0] cwe,
    input logic [31:0] ca, input logic [31:0] cd, input logic dr, input logic [3:0] dwe,
    input logic [31:0] da, input logic [31:0] dd, input logic [31:0] md,
    input logic stall, input logic gnt, input logic men, input logic [3:0] mwe,
    input logic [31:0] maddr, input logic [31:0] mwd, input logic [31:0] crd,
    input logic rv, input logic [31:0] drd);
    vec_t v;
    v.tag = tag; v.rst_n = rst_n; v.ce = ce; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dwe = dwe; v.da = da; v.dd = dd; v.md = md;
    v.stall = stall; v.gnt = gnt; v.men = men; v.mwe = mwe; v.maddr = maddr;
    v.mwd = mwd; v.crd = crd; v.rv = rv; v.drd = drd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    rst_ni = v.rst_n; cpu_en_i = v.ce; cpu_we_i = v.cwe; cpu_addr_i = v.ca; cpu_data_i = v.cd;
    dma_req_i = v.dr; dma_we_i = v.dwe; dma_addr_i = v.da; dma_data_i = v.dd; mem_data_i = v.md;
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    logic ok;
    ok = (cpu_stall_o === e.stall) && (dma_gnt_o === e.gnt) && (mem_en_o === e.men) &&
         (mem_we_o === e.mwe) && (!e.men || mem_addr_o === e.maddr) &&
         (e.mwe == 4'h0 || mem_data_o === e.mwd) && (cpu_data_o === e.crd) &&
         (dma_rvalid_o === e.rv) && (dma_data_o === e.drd);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d %s: got stall=%b gnt=%b en=%b we=%h addr=%h wd=%h crd=%h rv=%b drd=%h | want stall=%b gnt=%b en=%b we=%h addr=%h wd=%h crd=%h rv=%b drd=%h",
               idx, e.tag, cpu_stall_o, dma_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
               cpu_data_o, dma_rvalid_o, dma_data_o, e.stall, e.gnt, e.men, e.mwe, e.maddr,
               e.mwd, e.crd, e.rv, e.drd);
    end
  endtask

  initial begin
    vec_t idle;
    int   stalls;
    logic released;

    //   tag        rst ce cwe   ca          cd            dr dwe   da          dd            md              stall gnt en we    maddr       mwd           crd           rv drd
    add("reset",    0, 1, 4'h0, 32'h100,   32'h0,        1, 4'h0, 32'h200,   32'h0,        32'h11111111,   1,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("reset",    0, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'h22222222,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("cpurd",    1, 1, 4'h0, 32'h100,   32'h0,        0, 4'h0, 32'h0,     32'h0,        32'h0,          0,    0,  1, 4'h0, 32'h100,   32'h0,        32'h0,        0, 32'h0);
    add("cpurd",    1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'hDEADBEEF,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'hDEADBEEF, 0, 32'h0);
    add("idle",     1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'hCAFEF00D,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("burst",    1, 1, 4'hF, 32'h300,   32'hAAAA0001, 1, 4'h0, 32'h400,   32'h0,        32'h50000000,   1,    1,  1, 4'h0, 32'h400,   32'h0,        32'h0,        0, 32'h0);
    add("burst",    1, 1, 4'hF, 32'h300,   32'hAAAA0001, 1, 4'h0, 32'h404,   32'h0,        32'h50000001,   1,    1,  1, 4'h0, 32'h404,   32'h0,        32'h0,        1, 32'h50000001);
    add("burst",    1, 1, 4'hF, 32'h300,   32'hAAAA0001, 1, 4'h0, 32'h408,   32'h0,        32'h50000002,   1,    1,  1, 4'h0, 32'h408,   32'h0,        32'h0,        1, 32'h50000002);
    add("burst",    1, 1, 4'hF, 32'h300,   32'hAAAA0001, 1, 4'h0, 32'h40C,   32'h0,        32'h50000003,   1,    1,  1, 4'h0, 32'h40C,   32'h0,        32'h0,        1, 32'h50000003);
    add("burstcpu", 1, 1, 4'hF, 32'h300,   32'hAAAA0001, 1, 4'h0, 32'h410,   32'h0,        32'h50000004,   0,    0,  1, 4'hF, 32'h300,   32'hAAAA0001, 32'h0,        1, 32'h50000004);
    add("dmawr",    1, 0, 4'h0, 32'h0,     32'h0,        1, 4'h3, 32'h500,   32'h12345678, 32'h0,          0,    1,  1, 4'h3, 32'h500,   32'h12345678, 32'h0,        0, 32'h0);
    add("dmawr",    1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'h00000099,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("b2b",      1, 0, 4'h0, 32'h0,     32'h0,        1, 4'h0, 32'h200,   32'h0,        32'h0,          0,    1,  1, 4'h0, 32'h200,   32'h0,        32'h0,        0, 32'h0);
    add("b2b",      1, 1, 4'hF, 32'h300,   32'hBEEF0001, 0, 4'h0, 32'h0,     32'h0,        32'h0BADF00D,   0,    0,  1, 4'hF, 32'h300,   32'hBEEF0001, 32'h0,        1, 32'h0BADF00D);
    add("b2b",      1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'h00000077,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("rstrd",    1, 1, 4'h0, 32'h104,   32'h0,        1, 4'h0, 32'h240,   32'h0,        32'h0,          1,    1,  1, 4'h0, 32'h240,   32'h0,        32'h0,        0, 32'h0);
    add("rstrd",    0, 1, 4'h0, 32'h104,   32'h0,        1, 4'h0, 32'h240,   32'h0,        32'h66666666,   1,    0,  0, 4'h0, 32'h0,     32'h0,        32'h0,        0, 32'h0);
    add("rstcnt",   1, 1, 4'h0, 32'h104,   32'h0,        1, 4'hF, 32'h600,   32'hD0,       32'h00000055,   1,    1,  1, 4'hF, 32'h600,   32'hD0,       32'h0,        0, 32'h0);
    add("rstcnt",   1, 1, 4'h0, 32'h104,   32'h0,        1, 4'hF, 32'h600,   32'hD0,       32'h00000055,   1,    1,  1, 4'hF, 32'h600,   32'hD0,       32'h0,        0, 32'h0);
    add("rstcnt",   1, 1, 4'h0, 32'h104,   32'h0,        1, 4'hF, 32'h600,   32'hD0,       32'h00000055,   1,    1,  1, 4'hF, 32'h600,   32'hD0,       32'h0,        0, 32'h0);
    add("rstcnt",   1, 1, 4'h0, 32'h104,   32'h0,        1, 4'hF, 32'h600,   32'hD0,       32'h00000055,   1,    1,  1, 4'hF, 32'h600,   32'hD0,       32'h0,        0, 32'h0);
    add("rstcnt",   1, 1, 4'h0, 32'h104,   32'h0,        1, 4'hF, 32'h600,   32'hD0,       32'h00000055,   0,    0,  1, 4'h0, 32'h104,   32'h0,        32'h0,        0, 32'h0);
    add("rstcnt",   1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'hFEEDFACE,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'hFEEDFACE, 0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 0, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          0,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          1,    1,  1, 4'hF, 32'h700,   32'hE0,       32'h0,        0, 32'h0);
    add("drop",     1, 1, 4'h0, 32'h108,   32'h0,        1, 4'hF, 32'h700,   32'hE0,       32'h0,          0,    0,  1, 4'h0, 32'h108,   32'h0,        32'h0,        0, 32'h0);
    add("drop",     1, 0, 4'h0, 32'h0,     32'h0,        0, 4'h0, 32'h0,     32'h0,        32'h13579BDF,   0,    0,  0, 4'h0, 32'h0,     32'h0,        32'h13579BDF, 0, 32'h0);

    // Inputs change 1 time unit after a rising edge; outputs are sampled near the falling edge.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #4;
      check_vec(i, vecs[i]);
      @(posedge clk_i);
      #1;
    end

    // Hand sequence: continuous DMA writes with the CPU waiting; expect exactly 4 stalled cycles.
    idle = vecs[vecs.size() - 1];
    idle.md = 32'h0;
    drive(idle);
    cpu_en_i  = 1'b1;
    cpu_we_i  = 4'h0;
    cpu_addr_i = 32'h10C;
    dma_req_i = 1'b1;
    dma_we_i  = 4'hF;
    dma_addr_i = 32'h800;
    stalls   = 0;
    released = 1'b0;
    for (int c = 0; c < 20 && !released; c++) begin
      #4;
      if (!cpu_stall_o) released = 1'b1;
      else stalls++;
      @(posedge clk_i);
      #1;
    end
    n_vec++;
    if (!released || stalls != 4) begin
      n_bad++;
      $display("FAIL burst_wait: got %0d stalled cycles (released=%b), want 4 (released=1)", stalls, released);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
